// File: rtl/raycast_column_scheduler.sv
// Drives one raytracer across every screen column of a frame, sweeping the ray angle
// across the field of view and writing each column's hit cell (or a watchdog miss).
module raycast_column_scheduler #(
  parameter int unsigned NUM_COLS   = 160,
  parameter int unsigned COL_W      = 8,
  parameter logic [15:0] HALF_FOV   = 16'h1600,
  parameter logic [15:0] ANGLE_STEP = 16'h0046,
  parameter int unsigned MAX_CYCLES = 512,
  parameter int unsigned WD_W       = 10
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             frame_start_i,
  input  logic [13:0]      player_x_i,
  input  logic [12:0]      player_y_i,
  input  logic [7:0]       player_angle_i,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             rt_start_o,
  input  logic             rt_done_i,
  output logic             rt_abort_o,
  output logic [13:0]      rt_x_o,
  output logic [12:0]      rt_y_o,
  output logic [7:0]       rt_angle_o,
  input  logic [5:0]       rt_result_x_i,
  input  logic [4:0]       rt_result_y_i,
  output logic             col_wr_en_o,
  output logic [COL_W-1:0] col_addr_o,
  output logic             col_hit_o,
  output logic [5:0]       col_grid_x_o,
  output logic [4:0]       col_grid_y_o
);

  localparam int unsigned ACC_W = 16;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ISSUE, S_WAIT_RT, S_ABORT, S_WRITE, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [13:0]        px_q, px_d;
  logic [12:0]        py_q, py_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [COL_W-1:0]   col_addr_q, col_addr_d;
  logic               hit_q, hit_d;
  logic [5:0]         gx_q, gx_d;
  logic [4:0]         gy_q, gy_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               rt_start_q, rt_start_d;
  logic               rt_abort_q, rt_abort_d;
  logic               col_wr_en_q, col_wr_en_d;

  // Next-state logic; strobes are decoded from the upcoming state so they register cleanly.
  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    acc_d      = acc_q;
    col_d      = col_q;
    wd_d       = wd_q;
    col_addr_d = col_addr_q;
    hit_d      = hit_q;
    gx_d       = gx_q;
    gy_d       = gy_q;

    case (state_q)
      S_IDLE: begin
        if (frame_start_i) state_d = S_LATCH;
      end
      S_LATCH: begin
        px_d    = player_x_i;
        py_d    = player_y_i;
        acc_d   = {player_angle_i, 8'h00} - HALF_FOV;
        col_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT_RT;
      end
      S_WAIT_RT: begin
        // A completed ray takes priority over a timeout landing in the same cycle.
        if (rt_done_i) begin
          hit_d      = 1'b1;
          gx_d       = rt_result_x_i;
          gy_d       = rt_result_y_i;
          col_addr_d = col_q;
          state_d    = S_WRITE;
        end else if (wd_q == WD_LIMIT) begin
          state_d = S_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ABORT: begin
        hit_d      = 1'b0;
        gx_d       = '0;
        gy_d       = '0;
        col_addr_d = col_q;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (col_q == LAST_COL) begin
          state_d = S_DONE;
        end else begin
          col_d   = col_q + COL_W'(1);
          acc_d   = acc_q + ANGLE_STEP;
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);
    rt_start_d   = (state_d == S_ISSUE);
    rt_abort_d   = (state_d == S_ABORT);
    col_wr_en_d  = (state_d == S_WRITE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      px_q         <= '0;
      py_q         <= '0;
      acc_q        <= '0;
      col_q        <= '0;
      wd_q         <= '0;
      col_addr_q   <= '0;
      hit_q        <= 1'b0;
      gx_q         <= '0;
      gy_q         <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rt_start_q   <= 1'b0;
      rt_abort_q   <= 1'b0;
      col_wr_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      acc_q        <= acc_d;
      col_q        <= col_d;
      wd_q         <= wd_d;
      col_addr_q   <= col_addr_d;
      hit_q        <= hit_d;
      gx_q         <= gx_d;
      gy_q         <= gy_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rt_start_q   <= rt_start_d;
      rt_abort_q   <= rt_abort_d;
      col_wr_en_q  <= col_wr_en_d;
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign rt_start_o   = rt_start_q;
  assign rt_abort_o   = rt_abort_q;
  assign rt_x_o       = px_q;
  assign rt_y_o       = py_q;
  assign rt_angle_o   = acc_q[ACC_W-1:ACC_W-8];
  assign col_wr_en_o  = col_wr_en_q;
  assign col_addr_o   = col_addr_q;
  assign col_hit_o    = hit_q;
  assign col_grid_x_o = gx_q;
  assign col_grid_y_o = gy_q;

endmodule
